toy_bpu_l0btb_upd_ctrl: RTL and testbench



---
 rtl/toy_bpu_l0btb_upd_ctrl_if.sv | 52 +++++
 rtl/toy_bpu_l0btb_upd_ctrl.sv | 156 +++++++++++++++
 tb/tb_toy_bpu_l0btb_upd_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toy_bpu_l0btb_upd_ctrl_if.sv
// Shared update payload type and the request/issue bundle for the L0 BTB
// update scheduler.
//
// toy_bpu_pkg
//   l0btb_upd_pld_t : pred_pc, taken, tgt_pc of one L0 BTB update
//   BP0_TAG_WIDTH   : width of the pred_pc slice [BP0_TAG_WIDTH:1] that
//                     identifies an L0 BTB entry
//
// toy_bpu_l0btb_upd_ctrl_if
//   bpdec_upd_vld/rdy/pld : BP decoder correction request
//   be_upd_vld/rdy/pld    : backend resolve request
//   flush_i               : drop every queued update
//   l0btb_upd_vld/pld     : single-cycle update strobe to the L0 BTB
//   q_cnt_o               : update queue occupancy
//   master = requester/consumer side, slave = scheduler side
package toy_bpu_pkg;
  localparam int PC_W          = 32;
  localparam int BP0_TAG_WIDTH = 8;

  typedef struct packed {
    logic [PC_W-1:0] pred_pc;
    logic            taken;
    logic [PC_W-1:0] tgt_pc;
  } l0btb_upd_pld_t;
endpackage

interface toy_bpu_l0btb_upd_ctrl_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                       bpdec_upd_vld;
  logic                       bpdec_upd_rdy;
  toy_bpu_pkg::l0btb_upd_pld_t bpdec_upd_pld;
  logic                       be_upd_vld;
  logic                       be_upd_rdy;
  toy_bpu_pkg::l0btb_upd_pld_t be_upd_pld;
  logic                       flush_i;
  logic                       l0btb_upd_vld;
  toy_bpu_pkg::l0btb_upd_pld_t l0btb_upd_pld;
  logic [CNT_W-1:0]           q_cnt_o;

  modport master (
    output bpdec_upd_vld, bpdec_upd_pld, be_upd_vld, be_upd_pld, flush_i,
    input  bpdec_upd_rdy, be_upd_rdy, l0btb_upd_vld, l0btb_upd_pld, q_cnt_o
  );

  modport slave (
    input  bpdec_upd_vld, bpdec_upd_pld, be_upd_vld, be_upd_pld, flush_i,
    output bpdec_upd_rdy, be_upd_rdy, l0btb_upd_vld, l0btb_upd_pld, q_cnt_o
  );
endinterface

// File: rtl/toy_bpu_l0btb_upd_ctrl.sv
// L0 BTB update scheduler. Arbitrates BP decoder corrections and backend
// resolves into a small circular queue, drops a request that duplicates the
// queue tail, and issues the queue head to the single L0 BTB update port at
// most once every UPD_GAP+1 cycles.
//
// Ports
//   clk  : clock
//   rst  : synchronous active-high reset
//   upd  : slave side of toy_bpu_l0btb_upd_ctrl_if (requests in, ready,
//          L0 BTB update strobe/payload and queue occupancy out)
module toy_bpu_l0btb_upd_ctrl
  import toy_bpu_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int UPD_GAP      = 1,
  parameter int STARVE_LIMIT = 3
) (
  input logic                      clk,
  input logic                      rst,
  toy_bpu_l0btb_upd_ctrl_if.slave  upd
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (UPD_GAP > 1) ? $clog2(UPD_GAP) : 1;
  localparam int ST_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic {S_IDLE, S_GAP} state_t;

  // Two updates hit the same L0 BTB entry with the same outcome.
  function automatic logic same_upd(input l0btb_upd_pld_t a, input l0btb_upd_pld_t b);
    return (a.pred_pc[BP0_TAG_WIDTH:1] == b.pred_pc[BP0_TAG_WIDTH:1]) &&
           (a.taken == b.taken) && (a.tgt_pc == b.tgt_pc);
  endfunction

  l0btb_upd_pld_t   mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [ST_W-1:0]  starve_cnt;
  logic             issue_vld_p1;
  l0btb_upd_pld_t   issue_pld_p1;

  logic           q_empty;
  logic           q_full;
  logic           pop;
  logic           acc_ok;
  logic           be_sel;
  logic           bpdec_acc;
  logic           be_acc;
  logic           acc;
  logic           tail_live;
  logic           merge;
  logic           push;
  l0btb_upd_pld_t req_pld;
  l0btb_upd_pld_t tail_pld;

  // Stage p0: arbitration, merge detection and queue pop decision.
  always_comb begin
    q_empty  = (cnt == '0);
    q_full   = (cnt == CNT_W'(FIFO_DEPTH));
    pop      = !rst && !upd.flush_i && (state == S_IDLE) && !q_empty;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    acc_ok   = !rst && !upd.flush_i && (!q_full || pop);
    // Backend wins when the decoder is idle or the backend has starved.
    be_sel   = upd.be_upd_vld &&
               (!upd.bpdec_upd_vld || (starve_cnt >= ST_W'(STARVE_LIMIT)));
    bpdec_acc = acc_ok && !be_sel && upd.bpdec_upd_vld;
    be_acc    = acc_ok && be_sel && upd.be_upd_vld;
    acc       = bpdec_acc || be_acc;
    req_pld   = be_sel ? upd.be_upd_pld : upd.bpdec_upd_pld;
    tail_pld  = mem[wptr - PTR_W'(1)];
    // A single entry being popped this cycle is no longer a merge target.
    tail_live = !q_empty && !(pop && (cnt == CNT_W'(1)));
    merge     = acc && tail_live && same_upd(req_pld, tail_pld);
    push      = acc && !merge;
  end

  assign upd.bpdec_upd_rdy = acc_ok && !be_sel;
  assign upd.be_upd_rdy    = acc_ok && be_sel;

  // Queue storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= req_pld;
    end
  end

  // Stage p1: queue bookkeeping, issue FSM and registered L0 BTB strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      cnt          <= '0;
      state        <= S_IDLE;
      gap_cnt      <= '0;
      starve_cnt   <= '0;
      issue_vld_p1 <= 1'b0;
      issue_pld_p1 <= '0;
    end else begin
      issue_vld_p1 <= pop;
      if (pop) begin
        issue_pld_p1 <= mem[rptr];
      end

      if (!upd.be_upd_vld || be_acc) begin
        starve_cnt <= '0;
      end else if (bpdec_acc && (starve_cnt != ST_W'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + ST_W'(1);
      end

      if (upd.flush_i) begin
        wptr    <= '0;
        rptr    <= '0;
        cnt     <= '0;
        state   <= S_IDLE;
        gap_cnt <= '0;
      end else begin
        if (push) begin
          wptr <= wptr + PTR_W'(1);
        end
        if (pop) begin
          rptr <= rptr + PTR_W'(1);
        end
        cnt <= cnt + CNT_W'(push) - CNT_W'(pop);

        case (state)
          S_IDLE: begin
            if (pop && (UPD_GAP != 0)) begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end
          S_GAP: begin
            if (gap_cnt == GAP_W'(UPD_GAP - 1)) begin
              state   <= S_IDLE;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          default: begin
            state   <= S_IDLE;
            gap_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign upd.l0btb_upd_vld = issue_vld_p1;
  assign upd.l0btb_upd_pld = issue_pld_p1;
  assign upd.q_cnt_o       = cnt;

endmodule

// File: tb/tb_toy_bpu_l0btb_upd_ctrl.sv
// Self-checking bench for toy_bpu_l0btb_upd_ctrl: directed scenarios followed
// by randomized traffic, all checked every cycle against a queue-based model.
module tb_toy_bpu_l0btb_upd_ctrl;
  import toy_bpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int GAP   = 3;
  localparam int SLIM  = 3;
  localparam int TAGW  = BP0_TAG_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  toy_bpu_l0btb_upd_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();

  toy_bpu_l0btb_upd_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .UPD_GAP     (GAP),
    .STARVE_LIMIT(SLIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .upd(bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: pending updates as a plain queue, a cooldown count of
  // cycles before the next issue is allowed, and the starvation count.
  l0btb_upd_pld_t mq[$];
  int             cool   = 0;
  int             starve = 0;
  logic           m_vld  = 1'b0;
  l0btb_upd_pld_t m_pld  = '0;

  // Values sampled from the DUT in the most recent cycle.
  logic           s_bprdy, s_berdy, s_vld;
  l0btb_upd_pld_t s_pld;
  int             s_cnt;
  logic           d_bp_acc, d_be_acc;

  l0btb_upd_pld_t iss_q[$];
  int             iss_t[$];

  function automatic l0btb_upd_pld_t mk(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    l0btb_upd_pld_t p;
    p.pred_pc = pc;
    p.taken   = tk;
    p.tgt_pc  = tg;
    return p;
  endfunction

  function automatic bit dup(input l0btb_upd_pld_t a, input l0btb_upd_pld_t b);
    return (a.pred_pc[TAGW:1] == b.pred_pc[TAGW:1]) && (a.taken == b.taken) && (a.tgt_pc == b.tgt_pc);
  endfunction

  function automatic l0btb_upd_pld_t rnd_pld();
    logic [31:0] pc;
    pc = (32'($urandom_range(0, 3)) << 12) | (32'h40 * 32'($urandom_range(0, 3))) |
         32'($urandom_range(0, 1));
    return mk(pc, 1'($urandom_range(0, 1)), 32'h300 + 32'h4 * 32'($urandom_range(0, 1)));
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drv(input logic bv, input l0btb_upd_pld_t bp, input logic ev,
                     input l0btb_upd_pld_t ep, input logic fl, input logic r);
    bus.bpdec_upd_vld = bv;
    bus.bpdec_upd_pld = bp;
    bus.be_upd_vld    = ev;
    bus.be_upd_pld    = ep;
    bus.flush_i       = fl;
    rst               = r;
  endtask

  // One clock: inputs are already applied; sample and compare shortly after
  // the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit             pop_e, ok, besel, bp_a, be_a, acc, merge;
    int             sz;
    l0btb_upd_pld_t req;
    #1;
    s_bprdy = bus.bpdec_upd_rdy;
    s_berdy = bus.be_upd_rdy;
    s_vld   = bus.l0btb_upd_vld;
    s_pld   = bus.l0btb_upd_pld;
    s_cnt   = int'(bus.q_cnt_o);
    d_bp_acc = s_bprdy && bus.bpdec_upd_vld;
    d_be_acc = s_berdy && bus.be_upd_vld;
    if (s_vld) begin
      iss_q.push_back(s_pld);
      iss_t.push_back(cyc);
    end

    sz    = mq.size();
    pop_e = !rst && !bus.flush_i && (cool == 0) && (sz != 0);
    ok    = !rst && !bus.flush_i && ((sz < DEPTH) || pop_e);
    besel = bus.be_upd_vld && (!bus.bpdec_upd_vld || (starve >= SLIM));
    check("bpdec_rdy", 96'(s_bprdy), 96'(ok && !besel));
    check("be_rdy",    96'(s_berdy), 96'(ok && besel));
    check("upd_vld",   96'(s_vld),   96'(m_vld));
    check("upd_pld",   96'(s_pld),   96'(m_pld));
    check("q_cnt",     96'(s_cnt),   96'(sz));

    bp_a  = ok && !besel && bus.bpdec_upd_vld;
    be_a  = ok && besel && bus.be_upd_vld;
    acc   = bp_a || be_a;
    req   = be_a ? bus.be_upd_pld : bus.bpdec_upd_pld;
    merge = 1'b0;
    if (acc && (sz != 0) && !(pop_e && (sz == 1))) merge = dup(req, mq[sz-1]);

    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      cool   = 0;
      starve = 0;
      m_vld  = 1'b0;
      m_pld  = '0;
    end else begin
      m_vld = pop_e;
      if (!bus.be_upd_vld || be_a) starve = 0;
      else if (bp_a && (starve < SLIM)) starve++;
      if (bus.flush_i) begin
        mq.delete();
        cool = 0;
      end else begin
        if (pop_e) begin
          m_pld = mq.pop_front();
          cool  = GAP;
        end else if (cool > 0) begin
          cool--;
        end
        if (acc && !merge) mq.push_back(req);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drv(0, '0, 0, '0, 0, 0);
    repeat (n) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int             order[6];
    int             kb, ke, k, maxcnt;
    bit             stall_seen;
    int             n140;
    l0btb_upd_pld_t r;

    drv(0, '0, 0, '0, 0, 1);
    @(posedge clk);
    @(negedge clk);

    // Reset state, rdy held low while rst is high.
    cycle();
    check("reset_cnt", 96'(s_cnt), 96'(0));
    check("reset_bprdy", 96'(s_bprdy), 96'(0));
    check("reset_pld", 96'(s_pld), 96'(0));
    idle(2);

    // Single request: accepted, queued, issued two cycles after accept.
    drv(1, mk(32'h100, 1, 32'h200), 0, '0, 0, 0);
    cycle();
    check("single_rdy", 96'(s_bprdy), 96'(1));
    drv(0, '0, 0, '0, 0, 0);
    cycle();
    check("single_cnt1", 96'(s_cnt), 96'(1));
    check("single_vld_n1", 96'(s_vld), 96'(0));
    cycle();
    check("single_vld_n2", 96'(s_vld), 96'(1));
    check("single_pld", 96'(s_pld), 96'(mk(32'h100, 1, 32'h200)));
    check("single_cnt0", 96'(s_cnt), 96'(0));
    cycle();
    check("single_pulse", 96'(s_vld), 96'(0));
    idle(4);

    // Priority and starvation with both requesters always valid.
    kb = 0;
    ke = 0;
    for (int i = 0; i < 6; i++) begin
      drv(1, mk(32'h10 + 32'(2 * kb), 1, 32'h2000 + 32'(kb)), 1,
          mk(32'h90 + 32'(2 * ke), 1, 32'h3000 + 32'(ke)), 0, 0);
      cycle();
      order[i] = d_be_acc ? 2 : (d_bp_acc ? 1 : 0);
      if (d_bp_acc) kb++;
      if (d_be_acc) ke++;
    end
    check("prio_0", 96'(order[0]), 96'(1));
    check("prio_1", 96'(order[1]), 96'(1));
    check("prio_2", 96'(order[2]), 96'(1));
    check("prio_be_4th", 96'(order[3]), 96'(2));
    check("prio_4", 96'(order[4]), 96'(1));
    idle(30);

    // Merge of back-to-back duplicates while the queue is non-empty.
    iss_q.delete();
    iss_t.delete();
    drv(1, mk(32'h100, 1, 32'h200), 0, '0, 0, 0);
    cycle();
    drv(1, mk(32'h140, 1, 32'h300), 0, '0, 0, 0);
    cycle();
    cycle();
    check("merge_ack", 96'(s_bprdy), 96'(1));
    check("merge_cnt_a", 96'(s_cnt), 96'(1));
    drv(0, '0, 0, '0, 0, 0);
    cycle();
    check("merge_cnt_b", 96'(s_cnt), 96'(1));
    idle(16);
    n140 = 0;
    foreach (iss_q[i]) if (iss_q[i] == mk(32'h140, 1, 32'h300)) n140++;
    check("merge_one_issue", 96'(n140), 96'(1));

    drv(1, mk(32'h100, 1, 32'h200), 0, '0, 0, 0);
    cycle();
    drv(1, mk(32'h140, 1, 32'h300), 0, '0, 0, 0);
    cycle();
    drv(1, mk(32'h140, 0, 32'h300), 0, '0, 0, 0);
    cycle();
    drv(0, '0, 0, '0, 0, 0);
    cycle();
    check("nomerge_cnt", 96'(s_cnt), 96'(2));
    idle(16);

    // Full queue, back-pressure, issue spacing and order across wrap.
    iss_q.delete();
    iss_t.delete();
    k = 0;
    maxcnt = 0;
    stall_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (k < 7) drv(1, mk(32'h20 + 32'(2 * k), 1, 32'h500 + 32'(k)), 0, '0, 0, 0);
      else drv(0, '0, 0, '0, 0, 0);
      cycle();
      if (s_cnt > maxcnt) maxcnt = s_cnt;
      if ((k < 7) && !s_bprdy && (s_cnt == DEPTH)) stall_seen = 1;
      if (d_bp_acc) k++;
    end
    check("full_max_cnt", 96'(maxcnt), 96'(DEPTH));
    check("full_stall", 96'(stall_seen), 96'(1));
    check("full_n_issue", 96'(iss_q.size()), 96'(7));
    for (int i = 0; i < 7 && i < iss_q.size(); i++)
      check("full_order", 96'(iss_q[i]), 96'(mk(32'h20 + 32'(2 * i), 1, 32'h500 + 32'(i))));
    for (int i = 1; i < iss_t.size(); i++)
      check("full_spacing", 96'(iss_t[i] - iss_t[i-1]), 96'(GAP + 1));

    // Flush with three entries queued and the FSM in its gap.
    for (int i = 0; i < 4; i++) begin
      drv(1, mk(32'h60 + 32'(2 * i), 1, 32'h600 + 32'(i)), 0, '0, 0, 0);
      cycle();
    end
    drv(1, mk(32'h70, 1, 32'h700), 0, '0, 1, 0);
    cycle();
    check("flush_rdy", 96'(s_bprdy), 96'(0));
    check("flush_cnt_before", 96'(s_cnt), 96'(3));
    drv(0, '0, 0, '0, 0, 0);
    cycle();
    check("flush_cnt_after", 96'(s_cnt), 96'(0));
    iss_q.delete();
    idle(8);
    check("flush_no_issue", 96'(iss_q.size()), 96'(0));
    drv(1, mk(32'h180, 1, 32'h280), 0, '0, 0, 0);
    cycle();
    drv(0, '0, 0, '0, 0, 0);
    cycle();
    cycle();
    check("flush_relat_vld", 96'(s_vld), 96'(1));
    check("flush_relat_pld", 96'(s_pld), 96'(mk(32'h180, 1, 32'h280)));
    idle(6);

    // Reset mid-stream with entries queued.
    for (int i = 0; i < 3; i++) begin
      drv(1, mk(32'h1a + 32'(2 * i), 1, 32'h800 + 32'(i)), 0, '0, 0, 0);
      cycle();
    end
    drv(1, mk(32'h1f0, 1, 32'h900), 1, mk(32'h1e0, 0, 32'h901), 0, 1);
    cycle();
    check("rst_mid_bprdy", 96'(s_bprdy), 96'(0));
    check("rst_mid_berdy", 96'(s_berdy), 96'(0));
    drv(0, '0, 0, '0, 0, 0);
    cycle();
    check("rst_mid_cnt", 96'(s_cnt), 96'(0));
    check("rst_mid_vld", 96'(s_vld), 96'(0));
    check("rst_mid_pld", 96'(s_pld), 96'(0));
    iss_q.delete();
    idle(8);
    check("rst_mid_no_issue", 96'(iss_q.size()), 96'(0));

    // Randomized traffic; requesters hold their payload until accepted.
    for (int i = 0; i < 1500; i++) begin
      if (!bus.bpdec_upd_vld || d_bp_acc) begin
        bus.bpdec_upd_vld = ($urandom_range(0, 99) < 60);
        bus.bpdec_upd_pld = rnd_pld();
      end
      if (!bus.be_upd_vld || d_be_acc) begin
        bus.be_upd_vld = ($urandom_range(0, 99) < 50);
        r = rnd_pld();
        bus.be_upd_pld = ($urandom_range(0, 3) == 0) ? bus.bpdec_upd_pld : r;
      end
      bus.flush_i = ($urandom_range(0, 99) < 3);
      rst         = ($urandom_range(0, 199) == 0);
      cycle();
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
